// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, register-address width, the bubble instruction word and
// the bundle of per-register pipeline controls with its four fixed patterns.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // Encoding of an all-zero instruction word (sll $0,$0,0)
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } ctrlState_e;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExWrite;
    logic idExFlush;
    logic exMemWrite;
    logic memWbFlush;
  } pipeCtrl_t;

  // Free-running pipeline: everything advances, nothing is squashed
  localparam pipeCtrl_t CTRL_RUN =
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  // Data memory busy: freeze PC..EX/MEM, push a bubble into MEM/WB
  localparam pipeCtrl_t CTRL_MEM_STALL =
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  // Taken branch in EX: PC loads target, squash the two younger stages
  localparam pipeCtrl_t CTRL_BRANCH =
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Load-use: hold PC and IF/ID, bubble into ID/EX
  localparam pipeCtrl_t CTRL_LOAD_USE =
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  // True when a non-zero destination register matches a source register
  function automatic logic regHit(input logic [REG_ADDR_W-1:0] dest,
                                  input logic [REG_ADDR_W-1:0] src);
    return (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-signal / pipeline-control bundle between the datapath and the
// hazard controller. master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] RsAddr_ID;
  logic [REG_ADDR_W-1:0] RtAddr_ID;
  logic                  UsesRt_ID;
  logic                  MemRead_EX;
  logic [REG_ADDR_W-1:0] WriteReg_EX;
  logic                  BranchTaken_EX;
  logic                  MemReq_MEM;
  logic                  MemReady;

  logic PCWrite;
  logic IF_ID_Write;
  logic IF_ID_Flush;
  logic ID_EX_Write;
  logic ID_EX_Flush;
  logic EX_MEM_Write;
  logic MEM_WB_Flush;

  modport master (
    output RsAddr_ID, RtAddr_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
           BranchTaken_EX, MemReq_MEM, MemReady,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, MEM_WB_Flush
  );

  modport slave (
    input  RsAddr_ID, RtAddr_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
           BranchTaken_EX, MemReq_MEM, MemReady,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, MEM_WB_Flush
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source
// operand of the instruction in ID. $0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rsAddr,
  input  logic [REG_ADDR_W-1:0] rtAddr,
  input  logic                  usesRt,
  input  logic                  memRead,
  input  logic [REG_ADDR_W-1:0] writeReg,
  output logic                  loadUse
);

  assign loadUse = memRead &&
                   (regHit(writeReg, rsAddr) ||
                    (usesRt && regHit(writeReg, rtAddr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Priority per cycle: data-memory stall > taken-branch flush > load-use.
// Controls are decoded combinationally from the registered state and the
// live stage inputs so that a stall takes effect at the very next edge.
// Build option: define HAZARD_STATS_EN to get saturating stall/flush
// statistics counters; otherwise StallCycles/FlushEvents read as zero.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  pipe_hazard_ctrl_if.slave Bus,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
);

  localparam logic [1:0] LU_RELOAD  = 2'(LOAD_USE_STALLS - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic       MULTI_LU   = (LOAD_USE_STALLS > 1);

  ctrlState_e state;
  ctrlState_e nextState;
  ctrlState_e resumeState;
  ctrlState_e nextResume;
  logic [1:0] luCnt;
  logic [1:0] nextLuCnt;
  logic [7:0] waitCnt;
  logic [7:0] nextWaitCnt;
  logic       setTimeout;
  logic       loadUse;
  logic       memStall;
  logic       timedOut;
  logic       branch;
  pipeCtrl_t  ctrl;
  pipeCtrl_t  ctrlOut;

  hazard_detect uHazardDetect (
    .rsAddr   (Bus.RsAddr_ID),
    .rtAddr   (Bus.RtAddr_ID),
    .usesRt   (Bus.UsesRt_ID),
    .memRead  (Bus.MemRead_EX),
    .writeReg (Bus.WriteReg_EX),
    .loadUse  (loadUse)
  );

  assign memStall = Bus.MemReq_MEM && !Bus.MemReady;
  assign branch   = Bus.BranchTaken_EX;
  // Wait budget used up: this cycle releases the pipeline as if MemReady
  assign timedOut = (waitCnt == WAIT_LIMIT);

  // Next-state and control decode from current state and stage inputs
  always_comb begin
    ctrl        = CTRL_RUN;
    nextState   = state;
    nextResume  = resumeState;
    nextLuCnt   = luCnt;
    nextWaitCnt = waitCnt;
    setTimeout  = 1'b0;
    case (state)
      RUN, LU_STALL: begin
        if (memStall) begin
          // Freeze everything, remember where to come back to
          ctrl        = CTRL_MEM_STALL;
          nextState   = MEM_WAIT;
          nextResume  = state;
          nextWaitCnt = waitCnt + 8'd1;
          setTimeout  = ((waitCnt + 8'd1) == WAIT_LIMIT);
        end else if (branch) begin
          ctrl      = CTRL_BRANCH;
          nextState = RUN;
          nextLuCnt = 2'd0;
        end else if (state == LU_STALL) begin
          ctrl = CTRL_LOAD_USE;
          if (luCnt <= 2'd1) begin
            nextState = RUN;
            nextLuCnt = 2'd0;
          end else begin
            nextLuCnt = luCnt - 2'd1;
          end
        end else if (loadUse) begin
          ctrl = CTRL_LOAD_USE;
          if (MULTI_LU) begin
            nextState = LU_STALL;
            nextLuCnt = LU_RELOAD;
          end else begin
            nextState = RUN;
            nextLuCnt = 2'd0;
          end
        end else begin
          nextState = RUN;
        end
      end
      MEM_WAIT: begin
        if (!Bus.MemReady && !timedOut) begin
          // Still waiting; lu_cnt stays frozen
          ctrl        = CTRL_MEM_STALL;
          nextWaitCnt = waitCnt + 8'd1;
          setTimeout  = ((waitCnt + 8'd1) == WAIT_LIMIT);
        end else begin
          // Release cycle: controls follow the free-running rules
          nextWaitCnt = 8'd0;
          if (branch) begin
            ctrl = CTRL_BRANCH;
          end else if (loadUse) begin
            ctrl = CTRL_LOAD_USE;
          end else begin
            ctrl = CTRL_RUN;
          end
          if (timedOut || branch) begin
            nextState = RUN;
            nextLuCnt = 2'd0;
          end else if (resumeState == LU_STALL) begin
            nextState = LU_STALL;
          end else if (loadUse && MULTI_LU) begin
            nextState = LU_STALL;
            nextLuCnt = LU_RELOAD;
          end else begin
            nextState = RUN;
            nextLuCnt = 2'd0;
          end
          nextResume = RUN;
        end
      end
      default: begin
        ctrl        = CTRL_RUN;
        nextState   = RUN;
        nextResume  = RUN;
        nextLuCnt   = 2'd0;
        nextWaitCnt = 8'd0;
      end
    endcase
  end

  // Reset releases the whole pipeline regardless of state
  assign ctrlOut = Reset ? CTRL_RUN : ctrl;

  assign Bus.PCWrite      = ctrlOut.pcWrite;
  assign Bus.IF_ID_Write  = ctrlOut.ifIdWrite;
  assign Bus.IF_ID_Flush  = ctrlOut.ifIdFlush;
  assign Bus.ID_EX_Write  = ctrlOut.idExWrite;
  assign Bus.ID_EX_Flush  = ctrlOut.idExFlush;
  assign Bus.EX_MEM_Write = ctrlOut.exMemWrite;
  assign Bus.MEM_WB_Flush = ctrlOut.memWbFlush;

  // Controller state, stall/wait counters and sticky timeout flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= RUN;
      resumeState <= RUN;
      luCnt       <= 2'd0;
      waitCnt     <= 8'd0;
      MemTimeout  <= 1'b0;
    end else begin
      state       <= nextState;
      resumeState <= nextResume;
      luCnt       <= nextLuCnt;
      waitCnt     <= nextWaitCnt;
      if (setTimeout) begin
        MemTimeout <= 1'b1;
      end else begin
        MemTimeout <= MemTimeout;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Saturating counts of PC-hold cycles and branch flushes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallCnt <= {CNT_W{1'b0}};
      flushCnt <= {CNT_W{1'b0}};
    end else begin
      if (!ctrlOut.pcWrite && (stallCnt != CNT_MAX)) begin
        stallCnt <= stallCnt + CNT_ONE;
      end else begin
        stallCnt <= stallCnt;
      end
      if (ctrlOut.ifIdFlush && (flushCnt != CNT_MAX)) begin
        flushCnt <= flushCnt + CNT_ONE;
      end else begin
        flushCnt <= flushCnt;
      end
    end
  end

  assign StallCycles = stallCnt;
  assign FlushEvents = flushCnt;
`else
  assign StallCycles = {CNT_W{1'b0}};
  assign FlushEvents = {CNT_W{1'b0}};
`endif

endmodule
